// File: rtl/macro_util_pkg.sv
// ----------------------------------------------------------------------------
// macro_util_pkg
// Shared constants and helpers for the macro_* counter family.
//   MODE_WRAP / MODE_SAT : values for a counter's SATURATE parameter.
//   clamp(value, maxv)   : returns value limited to maxv (33-bit unsigned so
//                          that any WIDTH up to 32 fits without truncation).
// ----------------------------------------------------------------------------
package macro_util_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic logic [32:0] clamp(input logic [32:0] value,
                                          input logic [32:0] maxv);
        return (value > maxv) ? maxv : value;
    endfunction

endpackage

// File: rtl/macro_incdec_n.sv
// ----------------------------------------------------------------------------
// macro_incdec_n
// Combinational WIDTH-bit incrementer/decrementer, the parametrised successor
// of the 2-bit decrement ROM. The step is computed at WIDTH+1 bits and packed
// as {c, q}, so decrementing 0 yields {1, all-ones} and incrementing all-ones
// yields {1, 0}.
// Ports:
//   d   in  WIDTH  operand
//   dir in  1      1 = decrement, 0 = increment
//   en  in  1      0 = pass d through with c = 0
//   q   out WIDTH  result
//   c   out 1      carry (increment) or borrow (decrement)
// ----------------------------------------------------------------------------
module macro_incdec_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             c
);

    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

    logic [WIDTH:0] w_ext;
    logic [WIDTH:0] w_res;

    assign w_ext = {1'b0, d};

    always_comb begin
        w_res = w_ext;
        if (en) begin
            // Bit WIDTH of the wide result is the carry/borrow out.
            w_res = dir ? (w_ext - ONE) : (w_ext + ONE);
        end
    end

    assign q = w_res[WIDTH-1:0];
    assign c = w_res[WIDTH];

endmodule

// File: rtl/macro_counter_udn.sv
// ----------------------------------------------------------------------------
// macro_counter_udn
// Synchronous up/down counter with load, carry/borrow pulse and selectable
// wrap (SATURATE=0) or clamp-at-0/MAXV (SATURATE=1) behaviour.
// Priority each cycle: reset > load > (incr XOR decr) > hold.
// Ports:
//   clk    in  1      rising-edge clock
//   reset  in  1      synchronous active-high reset (q=INIT, c=0, sat=0)
//   load   in  1      load load_d (clamped to MAXV in saturate mode)
//   load_d in  WIDTH  load value
//   incr   in  1      increment request
//   decr   in  1      decrement request
//   q      out WIDTH  registered count
//   c      out 1      registered carry/borrow pulse (wrap mode only)
//   sat    out 1      registered clamp pulse (saturate mode only)
//   zero   out 1      q == 0
//   full   out 1      q == MAXV (saturate) or q == all-ones (wrap)
// ----------------------------------------------------------------------------
module macro_counter_udn
    import macro_util_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter int               SATURATE = MODE_WRAP,
    parameter logic [WIDTH-1:0] MAXV     = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] INIT     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_d,
    input  logic             incr,
    input  logic             decr,
    output logic [WIDTH-1:0] q,
    output logic             c,
    output logic             sat,
    output logic             zero,
    output logic             full
);

    localparam bit IS_SAT = (SATURATE != MODE_WRAP);

    logic [WIDTH-1:0] r_q;
    logic             r_c;
    logic             r_sat;

    logic             w_step;
    logic [WIDTH-1:0] w_next;
    logic             w_carry;
    logic [32:0]      w_load_wide;
    logic [WIDTH-1:0] w_load_val;
    logic             w_load_clamped;
    logic             w_at_top;
    logic             w_at_bot;
    logic             w_clamp_step;

    // Both requests together cancel out and are treated as hold.
    assign w_step = incr ^ decr;

    macro_incdec_n #(
        .WIDTH (WIDTH)
    ) u_incdec (
        .d   (r_q),
        .dir (decr),
        .en  (w_step),
        .q   (w_next),
        .c   (w_carry)
    );

    assign w_load_wide    = IS_SAT ? clamp(33'(load_d), 33'(MAXV)) : 33'(load_d);
    assign w_load_val     = w_load_wide[WIDTH-1:0];
    assign w_load_clamped = IS_SAT && (load_d > MAXV);

    assign w_at_top     = (r_q == MAXV);
    assign w_at_bot     = (r_q == '0);
    assign w_clamp_step = (incr && w_at_top) || (decr && w_at_bot);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q   <= INIT;
            r_c   <= 1'b0;
            r_sat <= 1'b0;
        end else begin
            r_c   <= 1'b0;
            r_sat <= 1'b0;
            if (load) begin
                r_q   <= w_load_val;
                r_sat <= w_load_clamped;
            end else if (w_step) begin
                if (IS_SAT) begin
                    // At a bound the count holds and the clamp is flagged.
                    if (w_clamp_step) begin
                        r_sat <= 1'b1;
                    end else begin
                        r_q <= w_next;
                    end
                end else begin
                    r_q <= w_next;
                    r_c <= w_carry;
                end
            end
        end
    end

    assign q    = r_q;
    assign c    = r_c;
    assign sat  = r_sat;
    assign zero = (r_q == '0);
    assign full = IS_SAT ? (r_q == MAXV) : (r_q == {WIDTH{1'b1}});

endmodule

// File: tb/tb_macro_counter_udn.sv
module tb_macro_counter_udn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // A: WIDTH=4 wrap, INIT=0
    logic       a_reset, a_load, a_incr, a_decr;
    logic [3:0] a_ld, a_q;
    logic       a_c, a_sat, a_zero, a_full;
    // B: WIDTH=4 saturate, MAXV=10
    logic       b_reset, b_load, b_incr, b_decr;
    logic [3:0] b_ld, b_q;
    logic       b_c, b_sat, b_zero, b_full;
    // C: WIDTH=8 wrap, INIT=0x55
    logic       c_reset, c_load, c_incr, c_decr;
    logic [7:0] c_ld, c_q;
    logic       c_c, c_sat, c_zero, c_full;
    // D: WIDTH=1 wrap
    logic       d_reset, d_load, d_incr, d_decr;
    logic [0:0] d_ld, d_q;
    logic       d_c, d_sat, d_zero, d_full;

    macro_counter_udn #(.WIDTH(4), .SATURATE(0), .INIT(4'd0)) u_a (
        .clk(clk), .reset(a_reset), .load(a_load), .load_d(a_ld), .incr(a_incr), .decr(a_decr),
        .q(a_q), .c(a_c), .sat(a_sat), .zero(a_zero), .full(a_full));

    macro_counter_udn #(.WIDTH(4), .SATURATE(1), .MAXV(4'd10), .INIT(4'd0)) u_b (
        .clk(clk), .reset(b_reset), .load(b_load), .load_d(b_ld), .incr(b_incr), .decr(b_decr),
        .q(b_q), .c(b_c), .sat(b_sat), .zero(b_zero), .full(b_full));

    macro_counter_udn #(.WIDTH(8), .SATURATE(0), .INIT(8'h55)) u_c (
        .clk(clk), .reset(c_reset), .load(c_load), .load_d(c_ld), .incr(c_incr), .decr(c_decr),
        .q(c_q), .c(c_c), .sat(c_sat), .zero(c_zero), .full(c_full));

    macro_counter_udn #(.WIDTH(1), .SATURATE(0), .INIT(1'b0)) u_d (
        .clk(clk), .reset(d_reset), .load(d_load), .load_d(d_ld), .incr(d_incr), .decr(d_decr),
        .q(d_q), .c(d_c), .sat(d_sat), .zero(d_zero), .full(d_full));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one counter step (reset handled by the caller).
    function automatic void mstep(input int w, input bit satm, input logic [31:0] maxv,
                                  input logic [31:0] qi, input bit ld, input logic [31:0] ldd,
                                  input bit inc, input bit dec,
                                  output logic [31:0] qo, output logic co, output logic so);
        logic [31:0] top;
        top = satm ? maxv : ((32'h1 << w) - 32'h1);
        qo = qi; co = 1'b0; so = 1'b0;
        if (ld) begin
            if (satm && ldd > maxv) begin qo = maxv; so = 1'b1; end
            else qo = ldd;
        end else if (inc && !dec) begin
            if (qi == top) begin
                if (satm) so = 1'b1;
                else begin qo = 32'h0; co = 1'b1; end
            end else qo = qi + 32'h1;
        end else if (dec && !inc) begin
            if (qi == 32'h0) begin
                if (satm) so = 1'b1;
                else begin qo = top; co = 1'b1; end
            end else qo = qi - 32'h1;
        end
    endfunction

    initial begin
        logic [31:0] ma, mb, md, nq;
        logic        nc, ns;
        a_reset = 1; a_load = 0; a_ld = '0; a_incr = 0; a_decr = 0;
        b_reset = 1; b_load = 0; b_ld = '0; b_incr = 0; b_decr = 0;
        c_reset = 1; c_load = 0; c_ld = '0; c_incr = 0; c_decr = 0;
        d_reset = 1; d_load = 0; d_ld = '0; d_incr = 0; d_decr = 0;
        tick();
        a_reset = 0; b_reset = 0; d_reset = 0;

        // Reset state
        chk("rst_a_q", 32'(a_q), 32'd0);
        chk("rst_a_c", 32'(a_c), 32'd0);
        chk("rst_a_zero", 32'(a_zero), 32'd1);
        chk("rst_a_full", 32'(a_full), 32'd0);
        chk("rst_b_q", 32'(b_q), 32'd0);
        chk("rst_b_sat", 32'(b_sat), 32'd0);
        chk("rst_c_q", 32'(c_q), 32'h55);
        chk("rst_d_q", 32'(d_q), 32'd0);

        // A: wrap borrow and carry
        a_decr = 1; tick(); a_decr = 0;
        chk("a_dec0_q", 32'(a_q), 32'hf);
        chk("a_dec0_c", 32'(a_c), 32'd1);
        chk("a_dec0_full", 32'(a_full), 32'd1);
        chk("a_dec0_sat", 32'(a_sat), 32'd0);
        tick();
        chk("a_idle_c", 32'(a_c), 32'd0);
        chk("a_idle_q", 32'(a_q), 32'hf);
        a_incr = 1; tick(); a_incr = 0;
        chk("a_incf_q", 32'(a_q), 32'd0);
        chk("a_incf_c", 32'(a_c), 32'd1);
        a_incr = 1; tick(); a_incr = 0;
        chk("a_inc0_q", 32'(a_q), 32'd1);
        chk("a_inc0_c", 32'(a_c), 32'd0);

        // A: incr and decr together hold
        a_load = 1; a_ld = 4'd7; tick(); a_load = 0;
        chk("a_ld7_q", 32'(a_q), 32'd7);
        a_incr = 1; a_decr = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("a_both_q", 32'(a_q), 32'd7);
            chk("a_both_c", 32'(a_c), 32'd0);
            chk("a_both_sat", 32'(a_sat), 32'd0);
        end
        a_incr = 0; a_decr = 0;

        // B: saturate mode
        b_load = 1; b_ld = 4'd13; tick(); b_load = 0;
        chk("b_ld13_q", 32'(b_q), 32'd10);
        chk("b_ld13_sat", 32'(b_sat), 32'd1);
        chk("b_ld13_full", 32'(b_full), 32'd1);
        b_incr = 1; tick(); b_incr = 0;
        chk("b_inctop_q", 32'(b_q), 32'd10);
        chk("b_inctop_sat", 32'(b_sat), 32'd1);
        chk("b_inctop_c", 32'(b_c), 32'd0);
        b_decr = 1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("b_dec_q", 32'(b_q), 32'(10 - i));
            chk("b_dec_sat", 32'(b_sat), 32'd0);
        end
        chk("b_dec_zero", 32'(b_zero), 32'd1);
        tick(); b_decr = 0;
        chk("b_decbot_q", 32'(b_q), 32'd0);
        chk("b_decbot_sat", 32'(b_sat), 32'd1);
        chk("b_decbot_c", 32'(b_c), 32'd0);
        b_load = 1; b_ld = 4'd10; tick(); b_load = 0;
        chk("b_ld10_q", 32'(b_q), 32'd10);
        chk("b_ld10_sat", 32'(b_sat), 32'd0);

        // C: reset overrides load/incr, then load beats incr
        c_reset = 1; c_load = 1; c_ld = 8'h20; c_incr = 1; tick();
        chk("c_rst_q", 32'(c_q), 32'h55);
        c_reset = 0; tick();
        chk("c_ld_q", 32'(c_q), 32'h20);
        chk("c_ld_c", 32'(c_c), 32'd0);
        c_load = 0; c_incr = 0;

        // D: WIDTH=1 toggle
        d_incr = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("d_tog_q", 32'(d_q), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("d_tog_c", 32'(d_c), (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("d_tog_full", 32'(d_full), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        d_incr = 0;

        // Random traffic on A, B and D against the reference model
        ma = 32'(a_q); mb = 32'(b_q); md = 32'(d_q);
        for (int i = 0; i < 600; i++) begin
            a_load = ($urandom_range(0, 15) == 0); a_ld = 4'($urandom);
            a_incr = 1'($urandom); a_decr = 1'($urandom);
            b_load = ($urandom_range(0, 15) == 0); b_ld = 4'($urandom);
            b_incr = 1'($urandom); b_decr = 1'($urandom);
            d_load = ($urandom_range(0, 15) == 0); d_ld = 1'($urandom);
            d_incr = 1'($urandom); d_decr = 1'($urandom);
            tick();
            mstep(4, 1'b0, 32'd15, ma, a_load, 32'(a_ld), a_incr, a_decr, nq, nc, ns);
            ma = nq;
            chk("rnd_a_q", 32'(a_q), nq);
            chk("rnd_a_c", 32'(a_c), 32'(nc));
            chk("rnd_a_sat", 32'(a_sat), 32'(ns));
            mstep(4, 1'b1, 32'd10, mb, b_load, 32'(b_ld), b_incr, b_decr, nq, nc, ns);
            mb = nq;
            chk("rnd_b_q", 32'(b_q), nq);
            chk("rnd_b_c", 32'(b_c), 32'(nc));
            chk("rnd_b_sat", 32'(b_sat), 32'(ns));
            mstep(1, 1'b0, 32'd1, md, d_load, 32'(d_ld), d_incr, d_decr, nq, nc, ns);
            md = nq;
            chk("rnd_d_q", 32'(d_q), nq);
            chk("rnd_d_c", 32'(d_c), 32'(nc));
            chk("rnd_d_sat", 32'(d_sat), 32'(ns));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
